// File: rtl/ar_rxd_pkg.sv
// Shared constants for the ARINC-429-style link: bit-rate defaults, field widths,
// receiver FSM state type and the rate -> half-bit-length helper. The transmitter
// uses the same helper, so both ends see identical timing.
package ar_rxd_pkg;

    localparam int unsigned FCLK_DEF    = 50_000_000;
    localparam int unsigned V1MB_DEF    = 1_000_000;
    localparam int unsigned V100KB_DEF  = 100_000;
    localparam int unsigned V50KB_DEF   = 50_000;
    localparam int unsigned V12_5KB_DEF = 12_500;

    localparam int unsigned NT_W      = 11;
    localparam int unsigned TMR_W     = NT_W + 2;
    localparam int unsigned BIT_CNT_W = 6;
    localparam int unsigned ADR_W     = 8;
    localparam int unsigned DAT_W     = 23;
    localparam int unsigned WORD_BITS = 32;

    typedef enum logic [1:0] {
        ST_WAIT_GAP = 2'd0,
        ST_IDLE     = 2'd1,
        ST_RX       = 2'd2
    } rx_state_e;

    // Half-bit length in clocks for a given bit rate.
    function automatic logic [NT_W-1:0] ar_half_bit(input int unsigned fclk,
                                                    input int unsigned rate);
        return NT_W'(fclk / (2 * rate));
    endfunction

endpackage

// File: rtl/ar_rxd_if.sv
// Receiver bundle: rate select and line pair in, decoded word and status out.
// master: line/rate driver and word consumer. slave: the receiver.
interface ar_rxd_if;
    import ar_rxd_pkg::*;

    logic [1:0]           Nvel;
    logic                 RXD1;
    logic                 RXD0;
    logic [ADR_W-1:0]     ADR_rx;
    logic [DAT_W-1:0]     DAT_rx;
    logic                 ce_wr;
    logic                 en_rx;
    logic [BIT_CNT_W-1:0] cb_bit_rx;
    logic                 err_par;
    logic                 err_len;
    logic                 err_line;

    modport master (
        output Nvel, RXD1, RXD0,
        input  ADR_rx, DAT_rx, ce_wr, en_rx, cb_bit_rx, err_par, err_len, err_line
    );

    modport slave (
        input  Nvel, RXD1, RXD0,
        output ADR_rx, DAT_rx, ce_wr, en_rx, cb_bit_rx, err_par, err_len, err_line
    );

endinterface

// File: rtl/ar_rx_sync.sv
// Two-flop synchronizer for the RXD1/RXD0 line pair plus rising-edge detect of
// line activity (either line high).
// Ports: clk, rst_n (sync, active low), rxd1/rxd0 async line inputs,
//        s1/s0 synchronized lines, act_rise_c combinational pulse-start flag.
module ar_rx_sync (
    input  logic clk,
    input  logic rst_n,
    input  logic rxd1,
    input  logic rxd0,
    output logic s1,
    output logic s0,
    output logic act_rise_c
);

    logic [1:0] meta_q;
    logic       act_q;

    // Metastability stage, settled stage, and one-clock-delayed activity.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            meta_q <= 2'b00;
            s1     <= 1'b0;
            s0     <= 1'b0;
            act_q  <= 1'b0;
        end else begin
            meta_q <= {rxd1, rxd0};
            s1     <= meta_q[1];
            s0     <= meta_q[0];
            act_q  <= s1 | s0;
        end
    end

    assign act_rise_c = (s1 | s0) & ~act_q;

endmodule

// File: rtl/ar_rxd.sv
// ARINC-429-style bipolar RZ receiver. Waits for an inter-word gap, then samples
// each pulse at mid-pulse, reassembles ADR (MSB first) and DAT (LSB first),
// checks odd parity and presents the word with a one-clock ce_wr strobe.
// Ports: clk, rst_n (sync, active low), rx (slave modport): Nvel rate select,
//        RXD1/RXD0 line pair, ADR_rx/DAT_rx last good word, ce_wr/err_par/
//        err_len/err_line one-clock strobes, en_rx word-in-progress, cb_bit_rx
//        next bit index.
module ar_rxd
    import ar_rxd_pkg::*;
#(
    parameter int unsigned Fclk    = FCLK_DEF,
    parameter int unsigned V1Mb    = V1MB_DEF,
    parameter int unsigned V100kb  = V100KB_DEF,
    parameter int unsigned V50kb   = V50KB_DEF,
    parameter int unsigned V12_5kb = V12_5KB_DEF
) (
    input  logic       clk,
    input  logic       rst_n,
    ar_rxd_if.slave    rx
);

    localparam logic [NT_W-1:0] NT3 = ar_half_bit(Fclk, V1Mb);
    localparam logic [NT_W-1:0] NT2 = ar_half_bit(Fclk, V100kb);
    localparam logic [NT_W-1:0] NT1 = ar_half_bit(Fclk, V50kb);
    localparam logic [NT_W-1:0] NT0 = ar_half_bit(Fclk, V12_5kb);

    logic s1, s0, act_rise_c, act_c;

    ar_rx_sync u_sync (
        .clk        (clk),
        .rst_n      (rst_n),
        .rxd1       (rx.RXD1),
        .rxd0       (rx.RXD0),
        .s1         (s1),
        .s0         (s0),
        .act_rise_c (act_rise_c)
    );

    assign act_c = s1 | s0;

    rx_state_e            state_q, state_nx;
    logic [TMR_W-1:0]     timer_q, timer_nx;
    logic [TMR_W-1:0]     gap_q, gap_nx;
    logic [BIT_CNT_W-1:0] cb_q, cb_nx;
    logic [ADR_W-1:0]     adr_sh_q, adr_sh_nx;
    logic [DAT_W-1:0]     dat_sh_q, dat_sh_nx;
    logic                 par_q, par_nx;
    logic [ADR_W-1:0]     adr_q, adr_nx;
    logic [DAT_W-1:0]     dat_q, dat_nx;
    logic                 ce_wr_q, ce_wr_nx;
    logic                 en_q, en_nx;
    logic                 err_par_q, err_par_nx;
    logic                 err_len_q, err_len_nx;
    logic                 err_line_q, err_line_nx;

    logic [NT_W-1:0]      nt_c;
    logic [TMR_W-1:0]     t_samp_c, t_tmo_c, gap_lim_c;
    logic                 bit_c;

    // Half-bit length for the current rate; a mid-word change takes effect at once.
    always_comb begin
        case (rx.Nvel)
            2'd3:    nt_c = NT3;
            2'd2:    nt_c = NT2;
            2'd1:    nt_c = NT1;
            default: nt_c = NT0;
        endcase
    end

    assign t_samp_c  = TMR_W'(nt_c >> 1);
    assign t_tmo_c   = TMR_W'(nt_c) * TMR_W'(3);
    assign gap_lim_c = TMR_W'(nt_c) << 2;
    assign bit_c     = s1;

    // State and output registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= ST_WAIT_GAP;
            timer_q    <= '0;
            gap_q      <= '0;
            cb_q       <= '0;
            adr_sh_q   <= '0;
            dat_sh_q   <= '0;
            par_q      <= 1'b0;
            adr_q      <= '0;
            dat_q      <= '0;
            ce_wr_q    <= 1'b0;
            en_q       <= 1'b0;
            err_par_q  <= 1'b0;
            err_len_q  <= 1'b0;
            err_line_q <= 1'b0;
        end else begin
            state_q    <= state_nx;
            timer_q    <= timer_nx;
            gap_q      <= gap_nx;
            cb_q       <= cb_nx;
            adr_sh_q   <= adr_sh_nx;
            dat_sh_q   <= dat_sh_nx;
            par_q      <= par_nx;
            adr_q      <= adr_nx;
            dat_q      <= dat_nx;
            ce_wr_q    <= ce_wr_nx;
            en_q       <= en_nx;
            err_par_q  <= err_par_nx;
            err_len_q  <= err_len_nx;
            err_line_q <= err_line_nx;
        end
    end

    // Next-state, counters, shift registers and strobes.
    always_comb begin
        state_nx    = state_q;
        cb_nx       = cb_q;
        adr_sh_nx   = adr_sh_q;
        dat_sh_nx   = dat_sh_q;
        par_nx      = par_q;
        adr_nx      = adr_q;
        dat_nx      = dat_q;
        en_nx       = en_q;
        ce_wr_nx    = 1'b0;
        err_par_nx  = 1'b0;
        err_len_nx  = 1'b0;
        err_line_nx = 1'b0;

        // Pulse timer: restarts on every pulse start, saturates otherwise.
        if (act_rise_c)
            timer_nx = '0;
        else if (timer_q == {TMR_W{1'b1}})
            timer_nx = timer_q;
        else
            timer_nx = timer_q + TMR_W'(1);

        // Consecutive idle-line clocks.
        if (act_c)
            gap_nx = '0;
        else if (gap_q == {TMR_W{1'b1}})
            gap_nx = gap_q;
        else
            gap_nx = gap_q + TMR_W'(1);

        case (state_q)
            ST_WAIT_GAP: begin
                en_nx = 1'b0;
                // gap_q excludes the current clock, hence the -1.
                if (!act_c && (gap_q >= gap_lim_c - TMR_W'(1)))
                    state_nx = ST_IDLE;
            end

            ST_IDLE: begin
                if (act_rise_c) begin
                    state_nx  = ST_RX;
                    en_nx     = 1'b1;
                    cb_nx     = '0;
                    par_nx    = 1'b1;
                    adr_sh_nx = '0;
                    dat_sh_nx = '0;
                end
            end

            ST_RX: begin
                if (timer_q == t_samp_c) begin
                    cb_nx = cb_q + BIT_CNT_W'(1);
                    if (s1 && s0) begin
                        err_line_nx = 1'b1;
                        en_nx       = 1'b0;
                        state_nx    = ST_WAIT_GAP;
                    end else if (cb_q < BIT_CNT_W'(ADR_W)) begin
                        adr_sh_nx = {adr_sh_q[ADR_W-2:0], bit_c};
                        par_nx    = par_q ^ bit_c;
                    end else if (cb_q < BIT_CNT_W'(WORD_BITS - 1)) begin
                        // Shift in from the top so the first data bit lands in DAT[0].
                        dat_sh_nx = {bit_c, dat_sh_q[DAT_W-1:1]};
                        par_nx    = par_q ^ bit_c;
                    end else begin
                        if (bit_c == par_q) begin
                            adr_nx   = adr_sh_q;
                            dat_nx   = dat_sh_q;
                            ce_wr_nx = 1'b1;
                        end else begin
                            err_par_nx = 1'b1;
                        end
                        en_nx    = 1'b0;
                        state_nx = ST_WAIT_GAP;
                    end
                end else if (timer_q >= t_tmo_c) begin
                    err_len_nx = 1'b1;
                    en_nx      = 1'b0;
                    state_nx   = ST_WAIT_GAP;
                end
            end

            default: begin
                en_nx    = 1'b0;
                state_nx = ST_WAIT_GAP;
            end
        endcase
    end

    assign rx.ADR_rx    = adr_q;
    assign rx.DAT_rx    = dat_q;
    assign rx.ce_wr     = ce_wr_q;
    assign rx.en_rx     = en_q;
    assign rx.cb_bit_rx = cb_q;
    assign rx.err_par   = err_par_q;
    assign rx.err_len   = err_len_q;
    assign rx.err_line  = err_line_q;

endmodule
